// File: rtl/map_tile_writer.sv
// Copies one TILE x TILE image from the tile ROM into a framebuffer tile slot,
// skipping pixels of colour KEY. Out-of-range destinations are rejected with err.
//
// state | meaning
// IDLE  | ready for a request
// RUN   | issuing ROM reads, writing the previous cycle's pixel
// DRAIN | writing the last pixel, no ROM issue
// DONE  | one-cycle done pulse (err valid)
module map_tile_writer #(
  parameter int          MAP_W = 576,
  parameter int          TILE  = 48,
  parameter int          COLS  = 12,
  parameter int          ROWS  = 15,
  parameter logic [11:0] KEY   = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  tile_id,
  input  logic [3:0]  tile_col,
  input  logic [3:0]  tile_row,
  output logic [15:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [11:0] fb_data,
  output logic        done,
  output logic        err
);

  localparam int CW = (TILE > 1) ? $clog2(TILE) : 1;
  localparam logic [CW-1:0] LAST = CW'(TILE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_id, r_col, r_row;
  logic [CW-1:0] r_tx, r_ty, r_txd, r_tyd;
  logic          r_wvalid, r_err;
  logic          w_accept, w_oor, w_last;

  assign req_ready = (r_state == IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign w_oor     = (32'(tile_col) >= 32'(COLS)) || (32'(tile_row) >= 32'(ROWS));
  assign w_last    = (r_tx == LAST) && (r_ty == LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = w_oor ? DONE : RUN;
      RUN:     if (w_last) w_next = DRAIN;
      DRAIN:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id     <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_tx     <= '0;
      r_ty     <= '0;
      r_txd    <= '0;
      r_tyd    <= '0;
      r_wvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // write stage trails the ROM issue by exactly one cycle
      r_txd    <= r_tx;
      r_tyd    <= r_ty;
      r_wvalid <= (r_state == RUN);
      if (w_accept) begin
        r_id  <= tile_id;
        r_col <= tile_col;
        r_row <= tile_row;
        r_err <= w_oor;
        r_tx  <= '0;
        r_ty  <= '0;
      end else if (r_state == RUN) begin
        if (r_tx == LAST) begin
          r_tx <= '0;
          r_ty <= w_last ? '0 : r_ty + CW'(1);
        end else begin
          r_tx <= r_tx + CW'(1);
        end
      end
    end
  end

  assign rom_addr = 16'(32'(r_id) * 32'(TILE * TILE) + 32'(r_ty) * 32'(TILE) + 32'(r_tx));
  assign fb_addr  = 19'(32'(MAP_W) * (32'(r_row) * 32'(TILE) + 32'(r_tyd))
                        + 32'(r_col) * 32'(TILE) + 32'(r_txd));
  assign fb_data  = r_wvalid ? rom_data : '0;
  assign fb_we    = r_wvalid && (rom_data != KEY);
  assign done     = (r_state == DONE);
  assign err      = r_err && (r_state == DONE);

endmodule

// File: tb/tb_map_tile_writer.sv
// Directed bench for map_tile_writer: ROM model with known pixel pattern,
// per-slot address/data/enable expectations and latency checks.
module tb_map_tile_writer;
  localparam int          MAP_W = 576;
  localparam int          TILE  = 48;
  localparam logic [11:0] KEY   = 12'hF0F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  tile_id = '0, tile_col = '0, tile_row = '0;
  logic [15:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [11:0] fb_data;
  logic        done, err;

  int n_checks = 0;
  int n_errors = 0;
  int rom_mode = 0;

  map_tile_writer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .tile_id(tile_id), .tile_col(tile_col), .tile_row(tile_row),
    .rom_addr(rom_addr), .rom_data(rom_data), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // mode 1 marks every odd ROM address transparent
  function automatic logic [11:0] pat(input logic [15:0] a, input int m);
    if (m == 1 && a[0]) return KEY;
    return {1'b0, a[10:0]};
  endfunction

  always @(posedge clk) rom_data <= pat(rom_addr, rom_mode);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic draw(input string nm, input logic [3:0] id, input logic [3:0] col,
                      input logic [3:0] row, input int mode, input bit oor);
    int nw, bad, done_cyc, rdy_cyc, first_a, last_a, first_r, errv, p, ea;
    logic [11:0] ed;
    nw = 0; bad = 0; done_cyc = -1; rdy_cyc = -1; first_a = -1; last_a = -1;
    first_r = -1; errv = -1;
    rom_mode = mode;
    @(posedge clk); #1;
    req_valid = 1'b1; tile_id = id; tile_col = col; tile_row = row;
    @(negedge clk);
    chk({nm, "_ready_c0"}, 32'(req_ready), 1);
    @(posedge clk); #1;
    // inputs scrambled while busy must be ignored
    req_valid = 1'b0; tile_id = ~id; tile_col = ~col; tile_row = ~row;
    for (int c = 1; c < 2400; c++) begin
      @(negedge clk);
      if (c == 1) first_r = int'(rom_addr);
      if (!oor && c >= 2 && c <= 2305) begin
        p  = c - 2;
        ea = MAP_W * (int'(row) * TILE + p / TILE) + int'(col) * TILE + p % TILE;
        ed = pat(16'(int'(id) * TILE * TILE + p), mode);
        if (fb_we !== (ed != KEY)) bad++;
        else if (fb_we && (int'(fb_addr) != ea || fb_data !== ed)) bad++;
      end else if (fb_we !== 1'b0) bad++;
      if (fb_we === 1'b1) begin
        nw++;
        if (first_a < 0) first_a = int'(fb_addr);
        last_a = int'(fb_addr);
        if (fb_data === KEY) bad++;
      end
      if (done === 1'b1 && done_cyc < 0) begin
        done_cyc = c;
        errv = int'(err);
      end
      if (req_ready === 1'b1) begin
        rdy_cyc = c;
        break;
      end
    end
    chk({nm, "_slots"}, bad, 0);
    chk({nm, "_err"}, errv, oor ? 1 : 0);
    if (oor) begin
      chk({nm, "_done_cyc"}, done_cyc, 1);
      chk({nm, "_ready_cyc"}, rdy_cyc, 2);
      chk({nm, "_writes"}, nw, 0);
    end else begin
      chk({nm, "_done_cyc"}, done_cyc, 2306);
      chk({nm, "_ready_cyc"}, rdy_cyc, 2307);
      chk({nm, "_writes"}, nw, mode == 1 ? 1152 : 2304);
      chk({nm, "_first_rom"}, first_r, int'(id) * TILE * TILE);
      chk({nm, "_first_fb"}, first_a, MAP_W * int'(row) * TILE + int'(col) * TILE);
      chk({nm, "_last_fb"}, last_a, MAP_W * (int'(row) * TILE + 47) + int'(col) * TILE
                                    + (mode == 1 ? 46 : 47));
    end
  endtask

  initial begin
    int nw, nd, d1, d2, bad, a2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_fb_addr", 32'(fb_addr), 0);
    chk("rst_fb_data", 32'(fb_data), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), 1);

    draw("t0", 4'd0, 4'd0, 4'd0, 0, 1'b0);
    draw("t3", 4'd3, 4'd11, 4'd14, 0, 1'b0);
    draw("key", 4'd5, 4'd2, 4'd3, 1, 1'b0);
    draw("col12", 4'd1, 4'd12, 4'd0, 0, 1'b1);
    draw("row15", 4'd1, 4'd0, 4'd15, 0, 1'b1);

    // reset in the middle of a draw
    rom_mode = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; tile_id = 4'd2; tile_col = 4'd1; tile_row = 4'd1;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int c = 1; c < 1000; c++) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_we", 32'(fb_we), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_rel", 32'(req_ready), 1);
    nw = 0; nd = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if (fb_we === 1'b1) nw++;
      if (done === 1'b1) nd++;
    end
    chk("mid_rst_writes", nw, 0);
    chk("mid_rst_done", nd, 0);
    draw("after_rst", 4'd4, 4'd6, 4'd7, 0, 1'b0);

    // back-to-back with req_valid held high; second draw targets column 1
    rom_mode = 0; nw = 0; d1 = -1; d2 = -1; bad = 0; a2 = -1;
    @(posedge clk); #1;
    req_valid = 1'b1; tile_id = 4'd1; tile_col = 4'd0; tile_row = 4'd0;
    @(posedge clk); #1 tile_col = 4'd1;
    for (int c = 1; c < 4700; c++) begin
      @(negedge clk);
      if (c == 2307) chk("b2b_ready_2307", 32'(req_ready), 1);
      if (c == 2308) req_valid = 1'b0;
      if (fb_we === 1'b1) begin
        nw++;
        if (c >= 2306 && c <= 2308) bad++;
        if (c > 2308 && a2 < 0) a2 = int'(fb_addr);
      end
      if (done === 1'b1) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
    end
    chk("b2b_done1", d1, 2306);
    chk("b2b_done2", d2, 4613);
    chk("b2b_writes", nw, 4608);
    chk("b2b_overlap", bad, 0);
    chk("b2b_first_fb2", a2, 48);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
